// File: rtl/sram_fifo_pkg.sv
// Shared sizing constants and helpers for the SRAM-backed FWFT FIFO controller.
package sram_fifo_pkg;

  // Address width is dictated by the attached 256 x 8 dual-port SRAM.
  localparam int ADDR_WIDTH       = 8;
  localparam int DEPTH            = 2 ** ADDR_WIDTH;
  localparam int DATA_WIDTH       = 8;
  // One extra bit so the SRAM count can reach DEPTH and the total can reach DEPTH+1.
  localparam int CNT_WIDTH        = ADDR_WIDTH + 1;
  localparam int AF_LEVEL_DEFAULT = 240;

  // Total occupancy: entries held in the SRAM plus the one parked in the output register.
  function automatic logic [CNT_WIDTH-1:0] total_count(
    input logic [CNT_WIDTH-1:0] mem_count,
    input logic                 out_valid
  );
    return mem_count + {{(CNT_WIDTH-1){1'b0}}, out_valid};
  endfunction

endpackage

// File: rtl/sram_fifo_out_stage.sv
// Output register of the FWFT FIFO: holds the head entry and decides when to
// prefetch the next word from SRAM port B.
module sram_fifo_out_stage
  import sram_fifo_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mem_nonempty,
  input  logic                  i_rd_ready,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic                  o_prefetch,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_pop;

  assign w_pop = r_valid && i_rd_ready;
  // Refill whenever the head slot is free or being vacated this cycle; the
  // registered SRAM count keeps a word written this cycle out of reach.
  assign o_prefetch = i_mem_nonempty && (!r_valid || w_pop);

  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Capture the prefetched word at the edge; a bare pop just empties the slot
  // and leaves the stale data untouched so SRAM high-Z is never latched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_prefetch) begin
      r_valid <= 1'b1;
      r_data  <= i_sram_data;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Runs a 256 x 8 dual-port SRAM as a first-word-fall-through FIFO: port A
// writes, port B prefetches into a registered output stage.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int ALMOST_FULL_LEVEL = AF_LEVEL_DEFAULT
) (
  input  logic                  Clk_In,
  input  logic                  Reset_N_In,
  input  logic [DATA_WIDTH-1:0] Wr_Data_In,
  input  logic                  Wr_Valid_In,
  output logic                  Wr_Ready_Out,
  output logic [DATA_WIDTH-1:0] Rd_Data_Out,
  output logic                  Rd_Valid_Out,
  input  logic                  Rd_Ready_In,
  output logic [CNT_WIDTH-1:0]  Count_Out,
  output logic                  Full_Out,
  output logic                  Empty_Out,
  output logic                  Almost_Full_Out,
  output logic                  Sram_Reset_Out,
  output logic [ADDR_WIDTH-1:0] Sram_A_Address_Out,
  output logic [DATA_WIDTH-1:0] Sram_A_Data_Out,
  output logic                  Sram_A_Write_Enable_Out,
  output logic                  Sram_A_Read_Enable_Out,
  output logic [ADDR_WIDTH-1:0] Sram_B_Address_Out,
  output logic                  Sram_B_Read_Enable_Out,
  output logic                  Sram_B_Write_Enable_Out,
  output logic [DATA_WIDTH-1:0] Sram_B_Data_Out,
  input  logic [DATA_WIDTH-1:0] Sram_B_Data_In
);

  localparam logic [CNT_WIDTH-1:0] C_DEPTH    = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] C_AF_LEVEL = CNT_WIDTH'(ALMOST_FULL_LEVEL);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_mem_count;

  logic                  w_full;
  logic                  w_push;
  logic                  w_prefetch;
  logic                  w_mem_nonempty;
  logic                  w_out_valid;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic [CNT_WIDTH-1:0]  w_count;

  assign w_full         = (r_mem_count == C_DEPTH);
  assign w_push         = Wr_Valid_In && !w_full;
  assign w_mem_nonempty = (r_mem_count != '0);

  sram_fifo_out_stage u_out_stage (
    .i_clk          (Clk_In),
    .i_rst_n        (Reset_N_In),
    .i_mem_nonempty (w_mem_nonempty),
    .i_rd_ready     (Rd_Ready_In),
    .i_sram_data    (Sram_B_Data_In),
    .o_prefetch     (w_prefetch),
    .o_valid        (w_out_valid),
    .o_data         (w_out_data)
  );

  // Advance pointers on each transfer; count moves only when push and
  // prefetch are not both happening.
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_prefetch) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_prefetch})
        2'b10:   r_mem_count <= r_mem_count + 1'b1;
        2'b01:   r_mem_count <= r_mem_count - 1'b1;
        default: r_mem_count <= r_mem_count;
      endcase
    end
  end

  // User-side status is derived purely from registered state.
  assign w_count         = total_count(r_mem_count, w_out_valid);
  assign Count_Out       = w_count;
  assign Full_Out        = w_full;
  assign Wr_Ready_Out    = !w_full;
  assign Empty_Out       = (w_count == '0);
  assign Almost_Full_Out = (w_count >= C_AF_LEVEL);
  assign Rd_Valid_Out    = w_out_valid;
  assign Rd_Data_Out     = w_out_data;

  // SRAM port controls; port A never reads because SRAM reads would win over the write.
  assign Sram_Reset_Out          = ~Reset_N_In;
  assign Sram_A_Address_Out      = r_wr_ptr;
  assign Sram_A_Data_Out         = Wr_Data_In;
  assign Sram_A_Write_Enable_Out = w_push;
  assign Sram_A_Read_Enable_Out  = 1'b0;
  assign Sram_B_Address_Out      = r_rd_ptr;
  assign Sram_B_Read_Enable_Out  = w_prefetch;
  assign Sram_B_Write_Enable_Out = 1'b0;
  assign Sram_B_Data_Out         = '0;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural dual-port SRAM model.
module tb_sram_fifo_ctrl;

  logic       Clk_In = 1'b0;
  logic       Reset_N_In = 1'b0;
  logic [7:0] Wr_Data_In = 8'h00;
  logic       Wr_Valid_In = 1'b0;
  logic       Wr_Ready_Out;
  logic [7:0] Rd_Data_Out;
  logic       Rd_Valid_Out;
  logic       Rd_Ready_In = 1'b0;
  logic [8:0] Count_Out;
  logic       Full_Out, Empty_Out, Almost_Full_Out;
  logic       Sram_Reset_Out;
  logic [7:0] Sram_A_Address_Out, Sram_A_Data_Out;
  logic       Sram_A_Write_Enable_Out, Sram_A_Read_Enable_Out;
  logic [7:0] Sram_B_Address_Out;
  logic       Sram_B_Read_Enable_Out, Sram_B_Write_Enable_Out;
  logic [7:0] Sram_B_Data_Out;
  wire  [7:0] Sram_B_Data_In;

  int checks = 0;
  int failures = 0;

  sram_fifo_ctrl dut (
    .Clk_In                  (Clk_In),
    .Reset_N_In              (Reset_N_In),
    .Wr_Data_In              (Wr_Data_In),
    .Wr_Valid_In             (Wr_Valid_In),
    .Wr_Ready_Out            (Wr_Ready_Out),
    .Rd_Data_Out             (Rd_Data_Out),
    .Rd_Valid_Out            (Rd_Valid_Out),
    .Rd_Ready_In             (Rd_Ready_In),
    .Count_Out               (Count_Out),
    .Full_Out                (Full_Out),
    .Empty_Out               (Empty_Out),
    .Almost_Full_Out         (Almost_Full_Out),
    .Sram_Reset_Out          (Sram_Reset_Out),
    .Sram_A_Address_Out      (Sram_A_Address_Out),
    .Sram_A_Data_Out         (Sram_A_Data_Out),
    .Sram_A_Write_Enable_Out (Sram_A_Write_Enable_Out),
    .Sram_A_Read_Enable_Out  (Sram_A_Read_Enable_Out),
    .Sram_B_Address_Out      (Sram_B_Address_Out),
    .Sram_B_Read_Enable_Out  (Sram_B_Read_Enable_Out),
    .Sram_B_Write_Enable_Out (Sram_B_Write_Enable_Out),
    .Sram_B_Data_Out         (Sram_B_Data_Out),
    .Sram_B_Data_In          (Sram_B_Data_In)
  );

  always #5 Clk_In = ~Clk_In;

  // Dual-port SRAM model: both ports act on the falling edge; port B drives
  // read data until the next falling edge, high-Z when not reading.
  logic [7:0] sram_mem [256];
  logic [7:0] sram_b_q = 8'h00;
  logic       sram_b_drive = 1'b0;
  assign Sram_B_Data_In = sram_b_drive ? sram_b_q : 8'hzz;

  always @(negedge Clk_In) begin
    if (Sram_A_Write_Enable_Out) sram_mem[Sram_A_Address_Out] = Sram_A_Data_Out;
    if (Sram_B_Read_Enable_Out) begin
      sram_b_q     = sram_mem[Sram_B_Address_Out];
      sram_b_drive = 1'b1;
    end else begin
      sram_b_drive = 1'b0;
    end
  end

  // One clock edge, then settle 1 ns before sampling or driving.
  task automatic step();
    @(posedge Clk_In);
    #1;
  endtask

  task automatic do_reset();
    Wr_Valid_In = 1'b0;
    Rd_Ready_In = 1'b0;
    Wr_Data_In  = 8'h00;
    Reset_N_In  = 1'b0;
    step();
    step();
    Reset_N_In = 1'b1;
    step();
  endtask

  // Push n words base, base+1, ... with no reads.
  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      Wr_Valid_In = 1'b1;
      Wr_Data_In  = base + 8'(i);
      step();
    end
    Wr_Valid_In = 1'b0;
  endtask

  task automatic test_reset();
    Reset_N_In = 1'b0;
    step();
    checks++; if (Sram_Reset_Out !== 1'b1) begin failures++; $display("FAIL rst_sram_reset_on actual=%0b expected=1", Sram_Reset_Out); end
    do_reset();
    checks++; if (Count_Out !== 9'd0) begin failures++; $display("FAIL rst_count actual=%0d expected=0", Count_Out); end
    checks++; if (Wr_Ready_Out !== 1'b1) begin failures++; $display("FAIL rst_wr_ready actual=%0b expected=1", Wr_Ready_Out); end
    checks++; if (Empty_Out !== 1'b1) begin failures++; $display("FAIL rst_empty actual=%0b expected=1", Empty_Out); end
    checks++; if (Full_Out !== 1'b0) begin failures++; $display("FAIL rst_full actual=%0b expected=0", Full_Out); end
    checks++; if (Almost_Full_Out !== 1'b0) begin failures++; $display("FAIL rst_afull actual=%0b expected=0", Almost_Full_Out); end
    checks++; if (Rd_Valid_Out !== 1'b0) begin failures++; $display("FAIL rst_rd_valid actual=%0b expected=0", Rd_Valid_Out); end
    checks++; if (Rd_Data_Out !== 8'h00) begin failures++; $display("FAIL rst_rd_data actual=%0h expected=00", Rd_Data_Out); end
    checks++; if (Sram_Reset_Out !== 1'b0) begin failures++; $display("FAIL rst_sram_reset_off actual=%0b expected=0", Sram_Reset_Out); end
    checks++; if ({Sram_A_Read_Enable_Out, Sram_B_Write_Enable_Out, Sram_B_Data_Out} !== 10'd0) begin
      failures++; $display("FAIL rst_const_ports actual=%0h expected=0", {Sram_A_Read_Enable_Out, Sram_B_Write_Enable_Out, Sram_B_Data_Out});
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single_push();
    do_reset();
    Wr_Valid_In = 1'b1;
    Wr_Data_In  = 8'hA5;
    #1;
    checks++; if (Sram_A_Write_Enable_Out !== 1'b1) begin failures++; $display("FAIL single_we actual=%0b expected=1", Sram_A_Write_Enable_Out); end
    checks++; if (Sram_A_Address_Out !== 8'h00) begin failures++; $display("FAIL single_waddr actual=%0h expected=00", Sram_A_Address_Out); end
    step();
    Wr_Valid_In = 1'b0;
    checks++; if (Rd_Valid_Out !== 1'b0) begin failures++; $display("FAIL single_valid_e1 actual=%0b expected=0", Rd_Valid_Out); end
    checks++; if (Count_Out !== 9'd1) begin failures++; $display("FAIL single_count_e1 actual=%0d expected=1", Count_Out); end
    checks++; if (Sram_B_Read_Enable_Out !== 1'b1) begin failures++; $display("FAIL single_prefetch actual=%0b expected=1", Sram_B_Read_Enable_Out); end
    step();
    checks++; if (Rd_Valid_Out !== 1'b1) begin failures++; $display("FAIL single_valid_e2 actual=%0b expected=1", Rd_Valid_Out); end
    checks++; if (Rd_Data_Out !== 8'hA5) begin failures++; $display("FAIL single_data actual=%0h expected=a5", Rd_Data_Out); end
    checks++; if (Count_Out !== 9'd1) begin failures++; $display("FAIL single_count_e2 actual=%0d expected=1", Count_Out); end
    $display("test_single_push done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp;
    do_reset();
    push_n(256, 8'h00);
    push_n(1, 8'h77);
    checks++; if (Count_Out !== 9'd257) begin failures++; $display("FAIL fill_count actual=%0d expected=257", Count_Out); end
    checks++; if (Full_Out !== 1'b1) begin failures++; $display("FAIL fill_full actual=%0b expected=1", Full_Out); end
    checks++; if (Wr_Ready_Out !== 1'b0) begin failures++; $display("FAIL fill_wr_ready actual=%0b expected=0", Wr_Ready_Out); end
    checks++; if (Almost_Full_Out !== 1'b1) begin failures++; $display("FAIL fill_afull actual=%0b expected=1", Almost_Full_Out); end
    Wr_Valid_In = 1'b1;
    Wr_Data_In  = 8'hEE;
    #1;
    checks++; if (Sram_A_Write_Enable_Out !== 1'b0) begin failures++; $display("FAIL fill_blocked_we actual=%0b expected=0", Sram_A_Write_Enable_Out); end
    step();
    Wr_Valid_In = 1'b0;
    checks++; if (Count_Out !== 9'd257) begin failures++; $display("FAIL fill_ignored_push actual=%0d expected=257", Count_Out); end
    Rd_Ready_In = 1'b1;
    for (int k = 0; k < 257; k++) begin
      exp = (k < 256) ? 8'(k) : 8'h77;
      checks++; if (Rd_Valid_Out !== 1'b1 || Rd_Data_Out !== exp) begin
        failures++; $display("FAIL drain_word k=%0d actual=%0b/%0h expected=1/%0h", k, Rd_Valid_Out, Rd_Data_Out, exp);
      end
      step();
    end
    Rd_Ready_In = 1'b0;
    checks++; if (Empty_Out !== 1'b1 || Rd_Valid_Out !== 1'b0) begin
      failures++; $display("FAIL drain_empty actual=%0b/%0b expected=1/0", Empty_Out, Rd_Valid_Out);
    end
    $display("test_fill_drain done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_back_to_back();
    do_reset();
    Rd_Ready_In = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      Wr_Valid_In = 1'b1;
      Wr_Data_In  = 8'h10 + 8'(n - 1);
      step();
      if (n == 1) begin
        checks++; if (Rd_Valid_Out !== 1'b0 || Count_Out !== 9'd1) begin
          failures++; $display("FAIL b2b_first actual=%0b/%0d expected=0/1", Rd_Valid_Out, Count_Out);
        end
      end else begin
        checks++; if (Rd_Valid_Out !== 1'b1 || Rd_Data_Out !== 8'h10 + 8'(n - 2) || Count_Out !== 9'd2) begin
          failures++; $display("FAIL b2b_word n=%0d actual=%0b/%0h/%0d expected=1/%0h/2", n, Rd_Valid_Out, Rd_Data_Out, Count_Out, 8'h10 + 8'(n - 2));
        end
      end
    end
    Wr_Valid_In = 1'b0;
    step();
    checks++; if (Rd_Data_Out !== 8'h37 || Rd_Valid_Out !== 1'b1) begin failures++; $display("FAIL b2b_last actual=%0b/%0h expected=1/37", Rd_Valid_Out, Rd_Data_Out); end
    step();
    Rd_Ready_In = 1'b0;
    checks++; if (Empty_Out !== 1'b1) begin failures++; $display("FAIL b2b_empty actual=%0b expected=1", Empty_Out); end
    $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_full_wrap();
    logic [7:0] exp;
    do_reset();
    push_n(257, 8'h00);
    checks++; if (Full_Out !== 1'b1) begin failures++; $display("FAIL wrap_full actual=%0b expected=1", Full_Out); end
    Rd_Ready_In = 1'b1;
    step();
    Rd_Ready_In = 1'b0;
    checks++; if (Full_Out !== 1'b0) begin failures++; $display("FAIL wrap_full_deassert actual=%0b expected=0", Full_Out); end
    checks++; if (Count_Out !== 9'd256) begin failures++; $display("FAIL wrap_count actual=%0d expected=256", Count_Out); end
    checks++; if (Rd_Data_Out !== 8'h01) begin failures++; $display("FAIL wrap_head actual=%0h expected=01", Rd_Data_Out); end
    repeat (1000) step();
    Wr_Valid_In = 1'b1;
    Wr_Data_In  = 8'hC3;
    #1;
    checks++; if (Sram_A_Address_Out !== 8'h01 || Sram_A_Write_Enable_Out !== 1'b1) begin
      failures++; $display("FAIL wrap_waddr actual=%0h/%0b expected=01/1", Sram_A_Address_Out, Sram_A_Write_Enable_Out);
    end
    step();
    Wr_Valid_In = 1'b0;
    checks++; if (Full_Out !== 1'b1 || Count_Out !== 9'd257) begin failures++; $display("FAIL wrap_refull actual=%0b/%0d expected=1/257", Full_Out, Count_Out); end
    Rd_Ready_In = 1'b1;
    for (int k = 0; k < 257; k++) begin
      exp = (k < 255) ? 8'(k + 1) : ((k == 255) ? 8'h00 : 8'hC3);
      checks++; if (Rd_Valid_Out !== 1'b1 || Rd_Data_Out !== exp) begin
        failures++; $display("FAIL wrap_drain k=%0d actual=%0b/%0h expected=1/%0h", k, Rd_Valid_Out, Rd_Data_Out, exp);
      end
      step();
    end
    Rd_Ready_In = 1'b0;
    checks++; if (Empty_Out !== 1'b1) begin failures++; $display("FAIL wrap_empty actual=%0b expected=1", Empty_Out); end
    $display("test_full_wrap done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_midburst();
    do_reset();
    push_n(50, 8'h40);
    checks++; if (Count_Out !== 9'd50) begin failures++; $display("FAIL mid_count actual=%0d expected=50", Count_Out); end
    Wr_Valid_In = 1'b1;
    Wr_Data_In  = 8'h99;
    #1;
    Reset_N_In = 1'b0;
    #1;
    checks++; if (Count_Out !== 9'd0 || Empty_Out !== 1'b1 || Wr_Ready_Out !== 1'b1) begin
      failures++; $display("FAIL mid_rst_flags actual=%0d/%0b/%0b expected=0/1/1", Count_Out, Empty_Out, Wr_Ready_Out);
    end
    checks++; if (Rd_Valid_Out !== 1'b0 || Rd_Data_Out !== 8'h00) begin
      failures++; $display("FAIL mid_rst_out actual=%0b/%0h expected=0/00", Rd_Valid_Out, Rd_Data_Out);
    end
    checks++; if (Sram_Reset_Out !== 1'b1 || Sram_A_Address_Out !== 8'h00 || Sram_B_Read_Enable_Out !== 1'b0) begin
      failures++; $display("FAIL mid_rst_sram actual=%0b/%0h/%0b expected=1/00/0", Sram_Reset_Out, Sram_A_Address_Out, Sram_B_Read_Enable_Out);
    end
    Wr_Valid_In = 1'b0;
    step();
    Reset_N_In = 1'b1;
    step();
    push_n(1, 8'h3E);
    checks++; if (Count_Out !== 9'd1 || Rd_Valid_Out !== 1'b0) begin
      failures++; $display("FAIL mid_after_push actual=%0d/%0b expected=1/0", Count_Out, Rd_Valid_Out);
    end
    step();
    checks++; if (Rd_Valid_Out !== 1'b1 || Rd_Data_Out !== 8'h3E) begin
      failures++; $display("FAIL mid_after_head actual=%0b/%0h expected=1/3e", Rd_Valid_Out, Rd_Data_Out);
    end
    Rd_Ready_In = 1'b1;
    step();
    Rd_Ready_In = 1'b0;
    checks++; if (Empty_Out !== 1'b1) begin failures++; $display("FAIL mid_after_pop actual=%0b expected=1", Empty_Out); end
    $display("test_reset_midburst done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_almost_full();
    do_reset();
    push_n(239, 8'h00);
    checks++; if (Count_Out !== 9'd239 || Almost_Full_Out !== 1'b0) begin
      failures++; $display("FAIL af_239 actual=%0d/%0b expected=239/0", Count_Out, Almost_Full_Out);
    end
    push_n(1, 8'hEF);
    checks++; if (Count_Out !== 9'd240 || Almost_Full_Out !== 1'b1) begin
      failures++; $display("FAIL af_240 actual=%0d/%0b expected=240/1", Count_Out, Almost_Full_Out);
    end
    Rd_Ready_In = 1'b1;
    step();
    Rd_Ready_In = 1'b0;
    checks++; if (Count_Out !== 9'd239 || Almost_Full_Out !== 1'b0) begin
      failures++; $display("FAIL af_pop actual=%0d/%0b expected=239/0", Count_Out, Almost_Full_Out);
    end
    checks++; if (Rd_Data_Out !== 8'h01) begin failures++; $display("FAIL af_head actual=%0h expected=01", Rd_Data_Out); end
    $display("test_almost_full done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #1;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_full_wrap();
    test_reset_midburst();
    test_almost_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
